// File: rtl/gamepad_pkg.sv
// Shared constants for the gamepad event unit: button map, register map, event width.
package gamepad_pkg;

  localparam int NUM_BUTTONS = 12;
  localparam int EVENT_W     = 2 * NUM_BUTTONS;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_X     = 7;
  localparam int BTN_Y     = 8;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 10;
  localparam int BTN_MODE  = 11;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_STATE  = 2'd1;
  localparam logic [1:0] REG_EVENT  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

endpackage

// File: rtl/gp_event_fifo.sv
// Synchronous circular-buffer FIFO; a push while full is accepted only if a pop frees a slot.
module gp_event_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: state flops use non-blocking assignments only; next-state logic lives in always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/gamepad_event_unit.sv
// Debounces the decoded gamepad buttons, logs press/release events in a FIFO,
// and exposes state, status and events on an Avalon-MM slave with a level irq.
module gamepad_event_unit
  import gamepad_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DEB_CYCLES = 8192
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_in,
  input  logic [1:0]             address,
  input  logic                   read,
  input  logic                   write,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic                   irq
);

  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_BUTTONS-1:0] raw_q, raw_d, cand_q, cand_d, stable_q, stable_d;
  logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
  logic                   irq_en_q, irq_en_d, overflow_q, overflow_d, irq_q, irq_d;
  logic [31:0]            readdata_q, readdata_d;

  logic                   ev_push, ev_pop, ctrl_wr;
  logic [EVENT_W-1:0]     ev_data, fifo_rdata;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic                   unused_wdata;

  assign unused_wdata = ^writedata[31:2];

  // Event layout: new button state in the upper half, changed mask in the lower half.
  always_comb begin
    raw_d     = btn_in;
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    stable_d  = stable_q;
    ev_push   = 1'b0;
    ev_data   = {cand_q, cand_q ^ stable_q};
    if (raw_q != cand_q) begin
      cand_d    = raw_q;
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DW'(DEB_CYCLES)) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
    if (deb_cnt_q == DW'(DEB_CYCLES - 1) && cand_q != stable_q) begin
      stable_d = cand_q;
      ev_push  = 1'b1;
    end
  end

  assign ev_pop  = read & (address == REG_EVENT) & ~fifo_empty;
  assign ctrl_wr = write & (address == REG_CTRL);

  gp_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ev_push),
    .pop   (ev_pop),
    .wdata (ev_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The overflow set is evaluated after the clear so that a simultaneous drop wins.
  always_comb begin
    irq_en_d   = ctrl_wr ? writedata[0] : irq_en_q;
    overflow_d = overflow_q;
    if (ctrl_wr && writedata[1]) overflow_d = 1'b0;
    if (ev_push && fifo_full && !ev_pop) overflow_d = 1'b1;
    irq_d      = irq_en_q & ~fifo_empty;
    readdata_d = '0;
    if (read) begin
      case (address)
        REG_STATUS: readdata_d = {21'b0, overflow_q, fifo_full, fifo_empty, 1'b0, 7'(fifo_count)};
        REG_STATE:  readdata_d = {20'b0, stable_q};
        REG_EVENT:  readdata_d = fifo_empty ? 32'b0 : {1'b1, 7'b0, fifo_rdata};
        default:    readdata_d = {31'b0, irq_en_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q      <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      deb_cnt_q  <= '0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      raw_q      <= raw_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      deb_cnt_q  <= deb_cnt_d;
      irq_en_q   <= irq_en_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gamepad_event_unit.sv
// Directed bench for gamepad_event_unit with a short debounce window.
module tb_gamepad_event_unit;

  localparam int FIFO_DEPTH = 16;
  localparam int DEB        = 32;
  localparam int SETTLE     = DEB + 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] btn_in;
  logic [1:0]  address;
  logic        read, write;
  logic [31:0] writedata, readdata;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  gamepad_event_unit #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick(1);
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick(1);
    write     = 1'b0;
  endtask

  task automatic set_btn(input logic [11:0] v);
    btn_in = v;
    tick(SETTLE);
  endtask

  logic [31:0] rd, exp;

  initial begin
    rst_n = 1'b0; btn_in = '0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    bus_read(2'd0, rd); chk("rst_status", rd, 32'h100);
    bus_read(2'd1, rd); chk("rst_state", rd, 32'h0);
    bus_read(2'd2, rd); chk("rst_event", rd, 32'h0);
    bus_read(2'd3, rd); chk("rst_ctrl", rd, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // Single press, then release
    set_btn(12'h001);
    chk("press_irq_disabled", {31'b0, irq}, 32'h0);
    bus_read(2'd1, rd); chk("press_state", rd, 32'h001);
    bus_read(2'd2, rd); chk("press_event", rd, 32'h8000_1001);
    bus_read(2'd0, rd); chk("press_status", rd, 32'h100);
    set_btn(12'h000);
    bus_read(2'd2, rd); chk("release_event", rd, 32'h8000_0001);

    // Glitch shorter than the debounce window
    btn_in = 12'h010;
    tick(DEB / 2);
    set_btn(12'h000);
    bus_read(2'd1, rd); chk("glitch_state", rd, 32'h0);
    bus_read(2'd0, rd); chk("glitch_status", rd, 32'h100);

    // Overflow: FIFO_DEPTH+1 changes without reading
    for (int i = 0; i <= FIFO_DEPTH; i++) set_btn((i % 2 == 0) ? 12'h400 : 12'h000);
    bus_read(2'd0, rd); chk("ovf_status", rd, 32'h610);
    bus_write(2'd3, 32'h2);
    bus_read(2'd0, rd); chk("ovf_cleared", rd, 32'h210);
    address = 2'd2;
    read    = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      tick(1);
      exp = (i % 2 == 0) ? 32'h8040_0400 : 32'h8000_0400;
      chk($sformatf("drain_%0d", i), readdata, exp);
    end
    read = 1'b0;
    bus_read(2'd0, rd); chk("drain_status", rd, 32'h100);

    // Interrupt: stable is 0x400 here, release it
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd); chk("ctrl_irq_en", rd, 32'h1);
    chk("irq_idle", {31'b0, irq}, 32'h0);
    btn_in = 12'h000;
    tick(DEB + 1);
    chk("irq_before_push", {31'b0, irq}, 32'h0);
    tick(2);
    chk("irq_after_push", {31'b0, irq}, 32'h1);
    bus_read(2'd2, rd); chk("irq_event", rd, 32'h8000_0400);
    chk("irq_at_pop", {31'b0, irq}, 32'h1);
    tick(1);
    chk("irq_fell", {31'b0, irq}, 32'h0);

    // Push while full coinciding with an EVENT read
    for (int i = 0; i < FIFO_DEPTH; i++) set_btn((i % 2 == 0) ? 12'h400 : 12'h000);
    bus_read(2'd0, rd); chk("full_status", rd, 32'h210);
    btn_in = 12'h400;
    // raw_q, cand_q load, then DEB-1 counts: the push lands on edge DEB+2.
    tick(DEB + 1);
    bus_read(2'd2, rd); chk("simul_event", rd, 32'h8040_0400);
    bus_read(2'd0, rd); chk("simul_status", rd, 32'h210);
    address = 2'd2;
    read    = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      tick(1);
      exp = (i == FIFO_DEPTH - 1 || (i + 1) % 2 == 0) ? 32'h8040_0400 : 32'h8000_0400;
      chk($sformatf("simul_drain_%0d", i), readdata, exp);
    end
    read = 1'b0;
    bus_read(2'd0, rd); chk("final_status", rd, 32'h100);
    chk("final_irq", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
